fpr_mul_arb: RTL
================

# fpr_mul_arb

Two-requester arbiter and result router for the sampler's shared double-precision multiplier (`fpr_cal`). It grants at most one multiply issue per cycle by driving `choose_a`/`choose_b`, and records the owner and tag of each issue in a latency-matched delay line. It returns each product to its owner with a single-cycle valid pulse. It sits between the sampler's two FPR consumers and the `fpr_cal` instance; operand buses go straight to `fpr_cal`, and this block drives only the selects.

## Interface
- `MUL_LAT`, 7: cycles from the issue edge (select high at `clk` rise) to the product being valid on `mul_out`; must be ≥ 2.
- `TAG_W`, 4: width of the requester tags.
- `clk` in 1: the single clock; everything is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `a_valid` in 1: requester A has operands on `fpr_cal` port A.
- `a_ready` out 1: A is granted this cycle (combinational).
- `a_tag` in TAG_W: A's request tag.
- `b_valid` / `b_ready` / `b_tag`: the same three signals for requester B.
- `choose_a` out 1: to `fpr_cal.choose_a`.
- `choose_b` out 1: to `fpr_cal.choose_b`.
- `mul_out` in 64: from `fpr_cal.data_out`.
- `res_data` out 64: product, shared by both requesters.
- `a_res_valid` / `a_res_tag` out 1 / TAG_W: result pulse and tag for A.
- `b_res_valid` / `b_res_tag` out 1 / TAG_W: result pulse and tag for B.
- `busy` out 1: at least one issue is in flight.

## Operation
- Grant is combinational from the valid inputs and the arbitration state.
  - `a_ready = choose_a = a_valid & grant_a`.
  - `b_ready = choose_b = b_valid & grant_b`.
  - `choose_a` and `choose_b` are never both high.
- Handshake:
  - Issue happens on an edge where `x_valid & x_ready`.
  - A requester keeps its operands and tag stable while it waits.
  - It may drop `valid` before it is granted.
- Arbitration, default round-robin:
  - A lone request wins immediately.
  - When both request, the side not granted most recently wins.
  - The `last` register updates on every issue and resets to B, so A wins the first contention.
- Tracking: a MUL_LAT-deep shift register of {valid, owner, tag}.
  - Stage 0 loads on every edge: valid = issue, owner = the winner, tag = the winner's tag.
  - The final stage drives the result outputs.
- Results:
  - `x_res_valid` = final valid & (owner == x).
  - `x_res_tag` = the final tag.
  - `res_data = mul_out` (pass-through).
- No result backpressure: requesters accept results unconditionally. Throughput is one issue per cycle, sustained.
- `busy` = OR of all tracking valids.

## Timing
- Reset values:
  - All tracking valids, `a_res_valid`, `b_res_valid` and `busy` are 0.
  - `a_res_tag` and `b_res_tag` are 0.
  - `last` = B.
  - `choose_a`, `choose_b`, `a_ready` and `b_ready` are 0 while `rst` is high, regardless of the valid inputs.
- Latency: an issue at edge t gives `x_res_valid` high for exactly the cycle between edges t+MUL_LAT-1 and t+MUL_LAT.
- Back-to-back issues give back-to-back result pulses in issue order. A/B interleaving and tags are preserved.
- Reset mid-operation:
  - All in-flight entries are discarded, and `fpr_cal` outputs for them never raise a result valid.
  - The first issue after `rst` falls follows the normal latency.
- Simultaneous issue edge and result edge are independent; no hazard arises.
- Neither requester valid: no select is asserted, and `fpr_cal` operand registers hold.

## Configuration
- Macro: `FPR_MUL_ARB_FIXPRI_EN`.
- Defined: fixed priority. A always wins contention, and B is granted only when `a_valid` is 0. The `last` register is removed.
- Undefined: round-robin as in Operation.

## Structure
- Package `fpr_arb_pkg`:
  - `owner_e` (OWN_A, OWN_B).
  - `track_t` struct {valid, owner, tag}.
  - Default constants `FPR_MUL_LAT = 7` and `FPR_TAG_W = 4`.
- Sub-module `fpr_arb_track`: the parameterised MUL_LAT-stage tracking delay line with asynchronous clear. The arbiter top instantiates it once.

## Test plan
- **Single A:** A issues 2.0×3.0 (0x4000000000000000, 0x4008000000000000) with tag 0x3 → exactly 7 cycles later, `a_res_valid` pulses once with `res_data` 0x4018000000000000 and `a_res_tag` 0x3; `b_res_valid` stays 0.
- **Contention, round-robin:** A and B both valid for 4 cycles → grants A, B, A, B; result pulses return in the same order with matching tags.
- **Fixed priority:** with `FPR_MUL_ARB_FIXPRI_EN` defined, A and B both valid for 3 cycles → B never granted; after A drops `valid`, B is granted on the next edge.
- **Streaming:** A issues 10 consecutive cycles with tags 0..9 → 10 consecutive `a_res_valid` cycles with tags 0..9; `busy` is high from the first issue through the last result.
- **Reset mid-flight:** 3 issues in flight, then `rst` pulses → no result valid follows; a new B issue returns after exactly MUL_LAT.
- **Withdrawn request:** B valid for 2 cycles while A wins, then B drops `valid` → B is never issued and no `b_res_valid` appears.

Source files
------------

// File: rtl/fpr_arb_pkg.sv
// Shared types and default constants for the fpr_cal multiplier arbiter.
//   owner_e   : which requester owns an in-flight multiply (A or B)
//   track_t   : one tracking stage {valid, owner, tag} at the default tag width
//   FPR_MUL_LAT / FPR_TAG_W : default multiplier latency and tag width
package fpr_arb_pkg;

    localparam int FPR_MUL_LAT = 7;
    localparam int FPR_TAG_W   = 4;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    typedef struct packed {
        logic                 valid;
        owner_e               owner;
        logic [FPR_TAG_W-1:0] tag;
    } track_t;

endpackage

// File: rtl/fpr_arb_track.sv
// Latency-matched tracking delay line for multiplier issues.
// Stage 0 captures {valid, owner, tag} on every edge; the last stage
// (DEPTH-1) lines up with the product appearing on fpr_cal's output.
// Ports:
//   clk, rst            : clock, asynchronous active-high clear
//   in_valid/owner/tag  : issue information for the current edge
//   out_valid/owner/tag : final stage contents
//   any_valid           : OR of every stage valid (something in flight)
// DEPTH must be at least 2.
module fpr_arb_track
    import fpr_arb_pkg::*;
#(
    parameter int DEPTH = FPR_MUL_LAT,
    parameter int TAG_W = FPR_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  owner_e           in_owner,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output owner_e           out_owner,
    output logic [TAG_W-1:0] out_tag,
    output logic             any_valid
);

    logic [DEPTH-1:0] valid_r;
    owner_e           owner_r [DEPTH];
    logic [TAG_W-1:0] tag_r   [DEPTH];

    // Shift the issue record one stage per clock; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                owner_r[i] <= OWN_A;
                tag_r[i]   <= {TAG_W{1'b0}};
            end
        end else begin
            valid_r    <= {valid_r[DEPTH-2:0], in_valid};
            owner_r[0] <= in_owner;
            tag_r[0]   <= in_tag;
            for (int i = 1; i < DEPTH; i++) begin
                owner_r[i] <= owner_r[i-1];
                tag_r[i]   <= tag_r[i-1];
            end
        end
    end

    assign out_valid = valid_r[DEPTH-1];
    assign out_owner = owner_r[DEPTH-1];
    assign out_tag   = tag_r[DEPTH-1];
    assign any_valid = |valid_r;

endmodule

// File: rtl/fpr_mul_arb.sv
// Two-requester arbiter and result router for the shared fpr_cal multiplier.
// Grants at most one issue per cycle through choose_a/choose_b, tracks the
// owner and tag of each issue for MUL_LAT cycles, and returns the product to
// its owner with a one-cycle valid pulse.
// Build option: FPR_MUL_ARB_FIXPRI_EN selects fixed priority (A always wins
// contention); left undefined, contention is resolved round-robin.
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   a_valid/a_ready/a_tag      : requester A handshake and tag
//   b_valid/b_ready/b_tag      : requester B handshake and tag
//   choose_a, choose_b         : operand selects to fpr_cal
//   mul_out                    : product from fpr_cal
//   res_data                   : product returned to both requesters
//   a_res_valid/a_res_tag      : result pulse and tag for A
//   b_res_valid/b_res_tag      : result pulse and tag for B
//   busy                       : at least one issue in flight
module fpr_mul_arb
    import fpr_arb_pkg::*;
#(
    parameter int MUL_LAT = FPR_MUL_LAT,
    parameter int TAG_W   = FPR_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [TAG_W-1:0] a_tag,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [TAG_W-1:0] b_tag,
    output logic             choose_a,
    output logic             choose_b,
    input  logic [63:0]      mul_out,
    output logic [63:0]      res_data,
    output logic             a_res_valid,
    output logic [TAG_W-1:0] a_res_tag,
    output logic             b_res_valid,
    output logic [TAG_W-1:0] b_res_tag,
    output logic             busy
);

    logic             grant_a_s;
    logic             grant_b_s;
    logic             issue_s;
    owner_e           win_owner_s;
    logic [TAG_W-1:0] win_tag_s;
    logic             out_valid_s;
    owner_e           out_owner_s;
    logic [TAG_W-1:0] out_tag_s;

`ifdef FPR_MUL_ARB_FIXPRI_EN
    // Fixed priority: A is always eligible, B only when A is not asking.
    always_comb begin
        grant_a_s = 1'b1;
        grant_b_s = ~a_valid;
    end
`else
    owner_e last_r;

    // Round-robin: under contention the side not granted most recently wins.
    always_comb begin
        grant_a_s = 1'b1;
        grant_b_s = 1'b1;
        if (a_valid && b_valid) begin
            grant_a_s = (last_r == OWN_B);
            grant_b_s = (last_r == OWN_A);
        end else begin
            grant_a_s = 1'b1;
            grant_b_s = 1'b1;
        end
    end

    // Remember the most recent winner; reset to B so A wins the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r <= OWN_B;
        end else if (issue_s) begin
            last_r <= win_owner_s;
        end else begin
            last_r <= last_r;
        end
    end
`endif

    // Selects are suppressed while reset is held so fpr_cal never loads operands then.
    always_comb begin
        choose_a    = a_valid & grant_a_s & ~rst;
        choose_b    = b_valid & grant_b_s & ~rst;
        a_ready     = choose_a;
        b_ready     = choose_b;
        issue_s     = choose_a | choose_b;
        win_owner_s = OWN_A;
        win_tag_s   = {TAG_W{1'b0}};
        if (choose_b) begin
            win_owner_s = OWN_B;
            win_tag_s   = b_tag;
        end else if (choose_a) begin
            win_owner_s = OWN_A;
            win_tag_s   = a_tag;
        end else begin
            win_owner_s = OWN_A;
            win_tag_s   = {TAG_W{1'b0}};
        end
    end

    fpr_arb_track #(
        .DEPTH (MUL_LAT),
        .TAG_W (TAG_W)
    ) u_track (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue_s),
        .in_owner  (win_owner_s),
        .in_tag    (win_tag_s),
        .out_valid (out_valid_s),
        .out_owner (out_owner_s),
        .out_tag   (out_tag_s),
        .any_valid (busy)
    );

    // Route the final tracking stage to the owning requester.
    always_comb begin
        a_res_valid = out_valid_s & (out_owner_s == OWN_A);
        b_res_valid = out_valid_s & (out_owner_s == OWN_B);
        a_res_tag   = out_tag_s;
        b_res_tag   = out_tag_s;
        res_data    = mul_out;
    end

endmodule
